// File: rtl/bubble_issue_ctrl_pkg.sv
// Shared definitions for the decode-to-execute bubble issue controller.
package bubble_issue_ctrl_pkg;

  // Width of the bubble request coming from decode hazard logic
  localparam int unsigned BUBBLE_W = 2;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_ENC = 32'h0000_0013;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StHold = 1'b1
  } state_e;

  // Requests of 3 are not legal from decode; saturate them to the 2-cycle maximum
  function automatic logic [BUBBLE_W-1:0] clamp_bubble(input logic [BUBBLE_W-1:0] req);
    return (req == 2'd3) ? 2'd2 : req;
  endfunction

endpackage

// File: rtl/bubble_issue_ctrl.sv
// ID/EX pipeline register with load-use bubble insertion, flush and memory-stall freeze.
module bubble_issue_ctrl
  import bubble_issue_ctrl_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_ENC,
  parameter int unsigned PERF_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [31:0]         id_instr,
  input  logic [31:0]         id_pc,
  input  logic [BUBBLE_W-1:0] id_bubble,
  input  logic                mem_stall,
  input  logic                redirect,
  output logic                if_stall,
  output logic [31:0]         ex_instr,
  output logic [31:0]         ex_pc,
  output logic                ex_valid,
  output logic [PERF_W-1:0]   bubble_count
);

  state_e              state_q;
  logic [BUBBLE_W-1:0] cnt_q;
  logic [31:0]         hold_instr_q;
  logic [31:0]         hold_pc_q;
  logic [BUBBLE_W-1:0] bubble_eff;

  assign bubble_eff = clamp_bubble(id_bubble);

  // Front-end stall: flush releases it, a memory stall forces it, otherwise hold while NOPs remain
  always_comb begin
    if_stall = 1'b0;
    if (redirect) begin
      if_stall = 1'b0;
    end else if (mem_stall) begin
      if_stall = 1'b1;
    end else if (state_q == StHold) begin
      if_stall = (cnt_q != '0);
    end else begin
      if_stall = id_valid && (bubble_eff != '0);
    end
  end

  // Issue FSM together with the ID/EX register and the bubble counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      hold_instr_q <= NOP_INSTR;
      hold_pc_q    <= '0;
      ex_instr     <= NOP_INSTR;
      ex_pc        <= '0;
      ex_valid     <= 1'b0;
      bubble_count <= '0;
    end else if (redirect) begin
      // Any held instruction is on the wrong path; drop it without counting
      ex_instr <= NOP_INSTR;
      ex_valid <= 1'b0;
      state_q  <= StIdle;
      cnt_q    <= '0;
    end else if (!mem_stall) begin
      unique case (state_q)
        StIdle: begin
          if (!id_valid) begin
            ex_instr <= NOP_INSTR;
            ex_valid <= 1'b0;
          end else if (bubble_eff == '0) begin
            ex_instr <= id_instr;
            ex_pc    <= id_pc;
            ex_valid <= 1'b1;
          end else begin
            ex_instr     <= NOP_INSTR;
            ex_valid     <= 1'b0;
            hold_instr_q <= id_instr;
            hold_pc_q    <= id_pc;
            cnt_q        <= bubble_eff - 2'd1;
            state_q      <= StHold;
            bubble_count <= bubble_count + PERF_W'(1);
          end
        end
        StHold: begin
          if (cnt_q != '0) begin
            ex_instr     <= NOP_INSTR;
            ex_valid     <= 1'b0;
            cnt_q        <= cnt_q - 2'd1;
            bubble_count <= bubble_count + PERF_W'(1);
          end else begin
            // Decode's copy of this instruction is not re-evaluated; the hazard is already covered
            ex_instr <= hold_instr_q;
            ex_pc    <= hold_pc_q;
            ex_valid <= 1'b1;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bubble_issue_ctrl.sv
// Randomised and directed bench for bubble_issue_ctrl against an issue-schedule queue model.
module tb_bubble_issue_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [1:0]  id_bubble;
  logic        mem_stall;
  logic        redirect;
  logic        if_stall;
  logic [31:0] ex_instr;
  logic [31:0] ex_pc;
  logic        ex_valid;
  logic [31:0] bubble_count;

  bubble_issue_ctrl #(
    .NOP_INSTR (NOP),
    .PERF_W    (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_instr     (id_instr),
    .id_pc        (id_pc),
    .id_bubble    (id_bubble),
    .mem_stall    (mem_stall),
    .redirect     (redirect),
    .if_stall     (if_stall),
    .ex_instr     (ex_instr),
    .ex_pc        (ex_pc),
    .ex_valid     (ex_valid),
    .bubble_count (bubble_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: every accepted decode slot becomes a schedule of issue slots
  // (kind 0 = idle NOP, 1 = hazard NOP, 2 = real instruction); one slot leaves per advancing edge.
  typedef struct {
    int          kind;
    logic [31:0] instr;
    logic [31:0] pc;
  } slot_t;

  slot_t       sched[$];
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_count;

  task automatic model_reset();
    sched.delete();
    m_instr = NOP;
    m_pc    = '0;
    m_valid = 1'b0;
    m_count = '0;
  endtask

  task automatic model_step(output logic stall);
    slot_t s;
    int    n;
    if (redirect) begin
      sched.delete();
      m_instr = NOP;
      m_valid = 1'b0;
      stall   = 1'b0;
    end else if (mem_stall) begin
      stall = 1'b1;
    end else begin
      if (sched.size() == 0) begin
        if (id_valid) begin
          n = (id_bubble == 2'd3) ? 2 : int'(id_bubble);
          for (int i = 0; i < n; i++) sched.push_back('{1, NOP, 32'h0});
          sched.push_back('{2, id_instr, id_pc});
        end else begin
          sched.push_back('{0, NOP, 32'h0});
        end
      end
      s     = sched.pop_front();
      stall = (sched.size() != 0);
      if (s.kind == 2) begin
        m_instr = s.instr;
        m_pc    = s.pc;
        m_valid = 1'b1;
      end else begin
        m_instr = NOP;
        m_valid = 1'b0;
      end
      if (s.kind == 1) m_count = m_count + 32'd1;
    end
  endtask

  // Starts and ends at a falling edge
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [1:0] b, input logic ms, input logic rd);
    logic exp_stall;
    id_valid  = v;
    id_instr  = ins;
    id_pc     = pc;
    id_bubble = b;
    mem_stall = ms;
    redirect  = rd;
    #1;
    model_step(exp_stall);
    check_eq("if_stall", 64'(if_stall), 64'(exp_stall));
    @(posedge clk);
    #1;
    check_eq("ex_instr", 64'(ex_instr), 64'(m_instr));
    check_eq("ex_pc", 64'(ex_pc), 64'(m_pc));
    check_eq("ex_valid", 64'(ex_valid), 64'(m_valid));
    check_eq("bubble_count", 64'(bubble_count), 64'(m_count));
    @(negedge clk);
  endtask

  // Asynchronous reset in the middle of the low phase; starts and ends at a falling edge
  task automatic do_reset();
    id_valid  = 1'b0;
    id_bubble = 2'd0;
    mem_stall = 1'b0;
    redirect  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_ex_valid", 64'(ex_valid), 64'd0);
    check_eq("rst_ex_instr", 64'(ex_instr), 64'h13);
    check_eq("rst_ex_pc", 64'(ex_pc), 64'd0);
    check_eq("rst_bubble_count", 64'(bubble_count), 64'd0);
    check_eq("rst_if_stall", 64'(if_stall), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b1;
    id_valid  = 1'b0;
    id_instr  = '0;
    id_pc     = '0;
    id_bubble = '0;
    mem_stall = 1'b0;
    redirect  = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // No-hazard issue
    cycle(1'b1, 32'h00A0_0093, 32'h100, 2'd0, 1'b0, 1'b0);
    check_eq("nohaz_instr", 64'(ex_instr), 64'h00A0_0093);
    check_eq("nohaz_valid", 64'(ex_valid), 64'd1);

    // Two-bubble hazard: decode keeps presenting the same instruction while stalled
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h0020_81B3, 32'h104, 2'd2, 1'b0, 1'b0);
    check_eq("b2_instr", 64'(ex_instr), 64'h0020_81B3);
    check_eq("b2_pc", 64'(ex_pc), 64'h104);
    check_eq("b2_count", 64'(bubble_count), 64'd2);

    // One-bubble hazard frozen by a memory stall while held
    do_reset();
    cycle(1'b1, 32'h0040_0113, 32'h200, 2'd1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h0040_0113, 32'h200, 2'd1, 1'b1, 1'b0);
    cycle(1'b1, 32'h0040_0113, 32'h200, 2'd1, 1'b0, 1'b0);
    check_eq("ms_valid", 64'(ex_valid), 64'd1);
    check_eq("ms_count", 64'(bubble_count), 64'd1);

    // Flush while holding with one NOP still due
    do_reset();
    cycle(1'b1, 32'h0030_0193, 32'h300, 2'd2, 1'b0, 1'b0);
    cycle(1'b1, 32'h0030_0193, 32'h300, 2'd2, 1'b0, 1'b1);
    check_eq("fl_valid", 64'(ex_valid), 64'd0);
    cycle(1'b1, 32'h0050_0213, 32'h400, 2'd0, 1'b0, 1'b0);
    check_eq("fl_next_instr", 64'(ex_instr), 64'h0050_0213);
    check_eq("fl_count", 64'(bubble_count), 64'd1);

    // Flush and memory stall together: flush wins
    do_reset();
    cycle(1'b1, 32'h0060_0293, 32'h500, 2'd1, 1'b1, 1'b1);
    check_eq("both_valid", 64'(ex_valid), 64'd0);

    // Illegal bubble request of 3 behaves as 2
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h0070_0313, 32'h600, 2'd3, 1'b0, 1'b0);
    check_eq("b3_count", 64'(bubble_count), 64'd2);

    // Random traffic, with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 3) != 0, $urandom, $urandom, 2'($urandom_range(0, 3)),
              $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
